// File: rtl/ddr3_master_pkg.sv
// Shared definitions for the DDR3 master write-flush path and its reader.
//   - FSM state encoding for the write flush
//   - DDR3 app command codes, default app-address step per 128-bit word
//   - DPB port-B rank/entry/address widths
//   - byte_mask(): app_wdf_mask for a partial word of 'bytecnt' left-aligned
//     valid bytes (0 means a full 16-byte word, so nothing is masked)
package ddr3_master_pkg;

  localparam int APP_ADDR_W = 28;
  localparam int RANK_W     = 2;
  localparam int ENTRY_W    = 8;
  localparam int DPB_ADDR_W = RANK_W + ENTRY_W;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  localparam logic [APP_ADDR_W-1:0] ADDR_STEP_DEF = 28'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_HI,
    ST_RD_LO,
    ST_WAIT,
    ST_XFER,
    ST_NEXT,
    ST_DONE
  } wr_state_t;

  // Marks which half of a 128-bit word a DPB read in flight belongs to.
  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_HI,
    TAG_LO
  } rd_tag_t;

  // Valid bytes sit in the high lanes; mask bit 15 covers data[127:120].
  function automatic logic [15:0] byte_mask(input logic [5:0] bytecnt);
    if (bytecnt == 6'd0) return 16'h0000;
    return 16'hFFFF >> bytecnt;
  endfunction

endpackage

// File: rtl/ddr3_app_wr_beat.sv
// Single 128-bit write beat on the Gowin DDR3 app interface.
// A start pulse latches addr/data/mask and raises app_en and app_wdf_wren
// together; each is dropped on its own handshake. done pulses (combinationally)
// in the cycle the last outstanding handshake completes. All app outputs stay
// stable while either side is stalled.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 1-cycle request to issue one write beat
//   addr, data, mask      beat contents, latched on start
//   done                  both command and data accepted
//   app_en/app_cmd/app_addr, app_rdy           command channel
//   app_wdf_wren/end/data/mask, app_wdf_rdy    write-data channel
module ddr3_app_wr_beat
  import ddr3_master_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [APP_ADDR_W-1:0] addr,
  input  logic [127:0]          data,
  input  logic [15:0]           mask,
  output logic                  done,
  output logic                  app_en,
  output logic [2:0]            app_cmd,
  output logic [APP_ADDR_W-1:0] app_addr,
  input  logic                  app_rdy,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  output logic [127:0]          app_wdf_data,
  output logic [15:0]           app_wdf_mask,
  input  logic                  app_wdf_rdy
);

  assign app_cmd     = APP_CMD_WR;
  assign app_wdf_end = app_wdf_wren;

  assign done = (app_en | app_wdf_wren)
              & (~app_en | app_rdy)
              & (~app_wdf_wren | app_wdf_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_addr     <= '0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
    end else if (start) begin
      app_en       <= 1'b1;
      app_wdf_wren <= 1'b1;
      app_addr     <= addr;
      app_wdf_data <= data;
      app_wdf_mask <= mask;
    end else begin
      if (app_en && app_rdy)            app_en       <= 1'b0;
      if (app_wdf_wren && app_wdf_rdy)  app_wdf_wren <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr3_master_wr_flush.sv
// Moves filled 64-bit DPB ranks into a DDR3 frame ring as 128-bit words and
// reports each completed JPEG frame (first app address, exact byte length).
// Optional feature macro: DDR3_WR_BYTEMASK_EN -- when defined, the partial
// last word of a chunk masks its padding bytes; otherwise the mask is always
// 0 and padding is written (o_frame_bytes stays exact either way).
// Ports:
//   i_pclk, i_rst_n                      clock, async active-low reset
//   i_wr_req, i_wr_buf_rank/128cnt/Bytecnt, i_chunk_last   chunk handshake in
//   o_wr_down                            chunk written, rank may be reused
//   o_dpb_b_addr, i_dpb_b_rd_data        DPB port-B read {rank, entry}
//   i_app_calib_done, o_app_*, i_app_rdy, i_app_wdf_rdy    DDR3 app interface
//   o_frame_valid/addr/bytes             completed-frame report
module ddr3_master_wr_flush
  import ddr3_master_pkg::*;
#(
  parameter logic [APP_ADDR_W-1:0] DDR_BASE    = 28'h000_0000,
  parameter logic [APP_ADDR_W-1:0] DDR_SPAN    = 28'h080_0000,
  parameter int                    BRAM_RD_LAT = 2,
  parameter logic [APP_ADDR_W-1:0] ADDR_STEP   = ADDR_STEP_DEF
) (
  input  logic                  i_pclk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_req,
  input  logic [RANK_W-1:0]     i_wr_buf_rank,
  input  logic [7:0]            i_wr_buf_128cnt,
  input  logic [5:0]            i_wr_buf_Bytecnt,
  input  logic                  i_chunk_last,
  output logic                  o_wr_down,
  output logic [DPB_ADDR_W-1:0] o_dpb_b_addr,
  input  logic [63:0]           i_dpb_b_rd_data,
  input  logic                  i_app_calib_done,
  output logic                  o_app_en,
  output logic [2:0]            o_app_cmd,
  output logic [APP_ADDR_W-1:0] o_app_addr,
  input  logic                  i_app_rdy,
  output logic                  o_app_wdf_wren,
  output logic                  o_app_wdf_end,
  output logic [127:0]          o_app_wdf_data,
  output logic [15:0]           o_app_wdf_mask,
  input  logic                  i_app_wdf_rdy,
  output logic                  o_frame_valid,
  output logic [APP_ADDR_W-1:0] o_frame_addr,
  output logic [23:0]           o_frame_bytes
);

  wr_state_t state, state_nxt;

  logic                  req_d, pending, req_edge, accept;
  logic [RANK_W-1:0]     rank_q;
  logic [7:0]            cnt_q;
  logic [5:0]            bytecnt_q;
  logic                  last_q;
  logic [6:0]            k_q;
  logic [APP_ADDR_W-1:0] ptr_q, ptr_inc, ptr_nxt, frame_addr_q;
  logic [23:0]           acc_q;
  logic                  last_word;
  logic [15:0]           word_mask;
  logic [63:0]           hi_q;
  rd_tag_t               tag_pipe [BRAM_RD_LAT];
  rd_tag_t               cur_tag;
  logic                  beat_start, beat_done;

  assign req_edge  = i_wr_req & ~req_d;
  assign accept    = (state == ST_IDLE) & i_app_calib_done & (req_edge | pending);
  assign last_word = ({1'b0, k_q} == cnt_q - 8'd1);

  // Wrap lands exactly on DDR_BASE in the same update, no idle slot.
  assign ptr_inc = ptr_q + ADDR_STEP;
  assign ptr_nxt = (ptr_inc == DDR_BASE + DDR_SPAN) ? DDR_BASE : ptr_inc;

`ifdef DDR3_WR_BYTEMASK_EN
  assign word_mask = last_word ? byte_mask(bytecnt_q) : 16'h0000;
`else
  assign word_mask = 16'h0000;
`endif

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_dpb_b_addr = '0;
    cur_tag      = TAG_NONE;
    beat_start   = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = (i_wr_buf_128cnt == 8'd0) ? ST_DONE : ST_RD_HI;
      ST_RD_HI: begin
        o_dpb_b_addr = {rank_q, k_q, 1'b0};
        cur_tag      = TAG_HI;
        state_nxt    = ST_RD_LO;
      end
      ST_RD_LO: begin
        o_dpb_b_addr = {rank_q, k_q, 1'b1};
        cur_tag      = TAG_LO;
        state_nxt    = ST_WAIT;
      end
      // The low entry is on the read port exactly when its tag leaves the
      // pipe, so the beat latches it straight from i_dpb_b_rd_data.
      ST_WAIT: if (tag_pipe[BRAM_RD_LAT-1] == TAG_LO) begin
        beat_start = 1'b1;
        state_nxt  = ST_XFER;
      end
      ST_XFER: if (beat_done) state_nxt = ST_NEXT;
      ST_NEXT: state_nxt = last_word ? ST_DONE : ST_RD_HI;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_d         <= 1'b0;
      pending       <= 1'b0;
      rank_q        <= '0;
      cnt_q         <= '0;
      bytecnt_q     <= '0;
      last_q        <= 1'b0;
      k_q           <= '0;
      ptr_q         <= DDR_BASE;
      frame_addr_q  <= DDR_BASE;
      acc_q         <= '0;
      o_wr_down     <= 1'b0;
      o_frame_valid <= 1'b0;
      o_frame_addr  <= '0;
      o_frame_bytes <= '0;
      for (int i = 0; i < BRAM_RD_LAT; i++) tag_pipe[i] <= TAG_NONE;
    end else begin
      req_d         <= i_wr_req;
      o_wr_down     <= 1'b0;
      o_frame_valid <= 1'b0;

      // One-deep pending: an edge coinciding with serving the pending one stays queued.
      if (accept)        pending <= pending & req_edge;
      else if (req_edge) pending <= 1'b1;

      if (accept) begin
        rank_q    <= i_wr_buf_rank;
        cnt_q     <= i_wr_buf_128cnt;
        bytecnt_q <= i_wr_buf_Bytecnt;
        last_q    <= i_chunk_last;
        k_q       <= '0;
      end

      if (state == ST_NEXT) begin
        ptr_q <= ptr_nxt;
        acc_q <= acc_q + ((last_word && bytecnt_q != 6'd0) ? {18'd0, bytecnt_q} : 24'd16);
        if (!last_word) k_q <= k_q + 7'd1;
      end

      if (state == ST_DONE) begin
        o_wr_down <= 1'b1;
        if (last_q) begin
          o_frame_valid <= 1'b1;
          o_frame_addr  <= frame_addr_q;
          o_frame_bytes <= acc_q;
          frame_addr_q  <= ptr_q;
          acc_q         <= '0;
        end
      end

      tag_pipe[0] <= cur_tag;
      for (int i = 1; i < BRAM_RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge i_pclk) begin
    if (tag_pipe[BRAM_RD_LAT-1] == TAG_HI) hi_q <= i_dpb_b_rd_data;
  end

  ddr3_app_wr_beat u_beat (
    .clk          (i_pclk),
    .rst_n        (i_rst_n),
    .start        (beat_start),
    .addr         (ptr_q),
    .data         ({hi_q, i_dpb_b_rd_data}),
    .mask         (word_mask),
    .done         (beat_done),
    .app_en       (o_app_en),
    .app_cmd      (o_app_cmd),
    .app_addr     (o_app_addr),
    .app_rdy      (i_app_rdy),
    .app_wdf_wren (o_app_wdf_wren),
    .app_wdf_end  (o_app_wdf_end),
    .app_wdf_data (o_app_wdf_data),
    .app_wdf_mask (o_app_wdf_mask),
    .app_wdf_rdy  (i_app_wdf_rdy)
  );

endmodule
